// File: rtl/rbm_spike_vote_pkg.sv
// Shared constants and state encoding for the RBM spike vote block.
// Optional margin output is enabled by defining RBM_VOTE_MARGIN_EN.
package rbm_spike_vote_pkg;

    localparam int RBM_NUM_CLASSES = 10;
    localparam int RBM_CLS_W       = 4;
    localparam int RBM_CNT_W       = 8;
    localparam int RBM_ITER_NUM    = 100;
    localparam int RBM_ITER_W      = 16;

    typedef enum logic [1:0] {
        VOTE_IDLE  = 2'd0,
        VOTE_ACCUM = 2'd1,
        VOTE_SCAN  = 2'd2,
        VOTE_DONE  = 2'd3
    } vote_state_t;

endpackage

// File: rtl/rbm_spike_vote_if.sv
// Spike input bus, control and result handshake of rbm_spike_vote.
// RBM_VOTE_MARGIN_EN adds the result_margin signal.
interface rbm_spike_vote_if
    import rbm_spike_vote_pkg::*;
#(
    parameter int CLS_W = RBM_CLS_W,
    parameter int CNT_W = RBM_CNT_W
);

    logic             start;
    logic             spike_valid;
    logic [CLS_W-1:0] spike_class;
    logic             spike;
    logic             iter_done;
    logic             result_ready;
    logic             result_valid;
    logic [CLS_W-1:0] result_class;
    logic [CNT_W-1:0] result_count;
    logic             busy;
    logic             sat_err;
`ifdef RBM_VOTE_MARGIN_EN
    logic [CNT_W-1:0] result_margin;
`endif

    modport master (
        output start,
        output spike_valid,
        output spike_class,
        output spike,
        output iter_done,
        output result_ready,
        input  result_valid,
        input  result_class,
        input  result_count,
        input  busy,
        input  sat_err
`ifdef RBM_VOTE_MARGIN_EN
        ,
        input  result_margin
`endif
    );

    modport slave (
        input  start,
        input  spike_valid,
        input  spike_class,
        input  spike,
        input  iter_done,
        input  result_ready,
        output result_valid,
        output result_class,
        output result_count,
        output busy,
        output sat_err
`ifdef RBM_VOTE_MARGIN_EN
        ,
        output result_margin
`endif
    );

endinterface

// File: rtl/rbm_vote_argmax_scan.sv
// Sequential argmax over the class counters, one class per cycle.
// RBM_VOTE_MARGIN_EN adds runner-up tracking.
module rbm_vote_argmax_scan
    import rbm_spike_vote_pkg::*;
#(
    parameter int NUM_CLASSES = RBM_NUM_CLASSES,
    parameter int CLS_W       = RBM_CLS_W,
    parameter int CNT_W       = RBM_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abort,
    input  logic             go,
    input  logic [CNT_W-1:0] cur_cnt,
    output logic [CLS_W-1:0] scan_idx,
    output logic             done,
    output logic [CLS_W-1:0] best_idx,
    output logic [CNT_W-1:0] best_cnt
`ifdef RBM_VOTE_MARGIN_EN
    ,
    output logic [CNT_W-1:0] second_cnt
`endif
);

    localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(NUM_CLASSES - 1);

    logic active;

    // Walk indices 0..N-1; strict compare keeps the lowest index on ties.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            active   <= 1'b0;
            done     <= 1'b0;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
`ifdef RBM_VOTE_MARGIN_EN
            second_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (go) begin
                active   <= 1'b1;
                scan_idx <= '0;
                best_idx <= '0;
                best_cnt <= '0;
`ifdef RBM_VOTE_MARGIN_EN
                second_cnt <= '0;
`endif
            end else if (active) begin
                if (cur_cnt > best_cnt) begin
                    best_idx <= scan_idx;
                    best_cnt <= cur_cnt;
`ifdef RBM_VOTE_MARGIN_EN
                    second_cnt <= best_cnt;
                end else if (cur_cnt > second_cnt) begin
                    second_cnt <= cur_cnt;
`endif
                end
                if (scan_idx == IDX_LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rbm_spike_vote.sv
// Per-class spike tally over ITER_NUM iterations, then argmax vote.
// RBM_VOTE_MARGIN_EN adds result_margin (best minus runner-up count).
module rbm_spike_vote
    import rbm_spike_vote_pkg::*;
#(
    parameter int NUM_CLASSES = RBM_NUM_CLASSES,
    parameter int CLS_W       = RBM_CLS_W,
    parameter int CNT_W       = RBM_CNT_W,
    parameter int ITER_NUM    = RBM_ITER_NUM
) (
    input logic             clock,
    input logic             reset,
    rbm_spike_vote_if.slave bus
);

    localparam logic [CLS_W:0] NC_EXT = (CLS_W + 1)'(NUM_CLASSES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RBM_ITER_W-1:0] ITER_LAST =
        RBM_ITER_W'(ITER_NUM - 1);

    vote_state_t           state;
    logic [RBM_ITER_W-1:0] iter_cnt;
    logic [CNT_W-1:0]      cnt [NUM_CLASSES];

    logic             result_valid_q;
    logic [CLS_W-1:0] result_class_q;
    logic [CNT_W-1:0] result_count_q;
    logic             busy_q;
    logic             sat_err_q;

    logic [CNT_W-1:0] cur_cnt;
    logic [CLS_W-1:0] scan_idx;
    logic             scan_done;
    logic             scan_go;
    logic [CLS_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
`ifdef RBM_VOTE_MARGIN_EN
    logic [CNT_W-1:0] second_cnt;
    logic [CNT_W-1:0] margin_q;
`endif

    // Counter read mux feeding the scan unit.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == CLS_W'(i)) cur_cnt = cnt[i];
        end
    end

    // Final iteration ends this cycle: launch the scan.
    always_comb begin
        scan_go = (state == VOTE_ACCUM) && bus.iter_done &&
                  (iter_cnt == ITER_LAST) && !bus.start;
    end

    rbm_vote_argmax_scan #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLS_W       (CLS_W),
        .CNT_W       (CNT_W)
    ) u_scan (
        .clock    (clock),
        .reset    (reset),
        .abort    (bus.start),
        .go       (scan_go),
        .cur_cnt  (cur_cnt),
        .scan_idx (scan_idx),
        .done     (scan_done),
        .best_idx (best_idx),
        .best_cnt (best_cnt)
`ifdef RBM_VOTE_MARGIN_EN
        ,
        .second_cnt (second_cnt)
`endif
    );

    // Vote FSM, counter bank and registered outputs.
    always_ff @(posedge clock) begin
        if (reset || bus.start) begin
            state    <= reset ? VOTE_IDLE : VOTE_ACCUM;
            iter_cnt <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_count_q <= '0;
            busy_q         <= !reset;
            sat_err_q      <= 1'b0;
`ifdef RBM_VOTE_MARGIN_EN
            margin_q <= '0;
`endif
        end else begin
            unique case (state)
                VOTE_IDLE: begin
                end
                VOTE_ACCUM: begin
                    if (bus.spike_valid) begin
                        if ({1'b0, bus.spike_class} >= NC_EXT) begin
                            sat_err_q <= 1'b1;
                        end else if (bus.spike) begin
                            for (int i = 0; i < NUM_CLASSES; i++) begin
                                if (bus.spike_class == CLS_W'(i)) begin
                                    if (cnt[i] == CNT_MAX)
                                        sat_err_q <= 1'b1;
                                    else
                                        cnt[i] <= cnt[i] + 1'b1;
                                end
                            end
                        end
                    end
                    if (bus.iter_done) begin
                        iter_cnt <= iter_cnt + 1'b1;
                        if (iter_cnt == ITER_LAST) state <= VOTE_SCAN;
                    end
                end
                VOTE_SCAN: begin
                    if (scan_done) begin
                        state          <= VOTE_DONE;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_class_q <= best_idx;
                        result_count_q <= best_cnt;
`ifdef RBM_VOTE_MARGIN_EN
                        margin_q <= (NUM_CLASSES == 1) ? '0 :
                                    best_cnt - second_cnt;
`endif
                    end
                end
                VOTE_DONE: begin
                    if (bus.result_ready) begin
                        state          <= VOTE_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.result_class = result_class_q;
    assign bus.result_count = result_count_q;
    assign bus.busy         = busy_q;
    assign bus.sat_err      = sat_err_q;
`ifdef RBM_VOTE_MARGIN_EN
    assign bus.result_margin = margin_q;
`endif

endmodule

// File: tb/tb_rbm_spike_vote.sv
// Scoreboard bench for rbm_spike_vote (main and narrow-counter instance).
// Margin checks are compiled in when RBM_VOTE_MARGIN_EN is defined.
module tb_rbm_spike_vote;
    import rbm_spike_vote_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rbm_spike_vote_if #(.CLS_W(4), .CNT_W(8)) bus ();
    rbm_spike_vote_if #(.CLS_W(4), .CNT_W(3)) bus_s ();

    rbm_spike_vote #(
        .NUM_CLASSES (10),
        .CLS_W       (4),
        .CNT_W       (8),
        .ITER_NUM    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    rbm_spike_vote #(
        .NUM_CLASSES (10),
        .CLS_W       (4),
        .CNT_W       (3),
        .ITER_NUM    (1)
    ) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        int cls;
        int cnt;
        int margin;
    } exp_t;

    exp_t sb[$];
    int   model[10];
    int   vectors = 0;
    int   errors  = 0;

    task automatic clear_inputs();
        bus.start = 0; bus.spike_valid = 0; bus.spike_class = '0;
        bus.spike = 0; bus.iter_done = 0;
        bus_s.start = 0; bus_s.spike_valid = 0; bus_s.spike_class = '0;
        bus_s.spike = 0; bus_s.iter_done = 0;
    endtask

    task automatic cyc(input bit v, input int cls, input bit s, input bit itd);
        bus.spike_valid = v;
        bus.spike_class = 4'(cls);
        bus.spike       = s;
        bus.iter_done   = itd;
        if (v && s && cls < 10 && model[cls] < 255) model[cls]++;
        @(negedge clock);
        bus.spike_valid = 0; bus.spike = 0;
        bus.iter_done = 0; bus.spike_class = '0;
    endtask

    task automatic do_start();
        bus.start = 1;
        @(negedge clock);
        bus.start = 0;
        for (int i = 0; i < 10; i++) model[i] = 0;
    endtask

    // Expected winner: first index holding the maximum; margin vs the rest.
    task automatic push_expected();
        exp_t e;
        int mx, other;
        mx = 0;
        for (int i = 0; i < 10; i++) if (model[i] > mx) mx = model[i];
        e.cls = 0;
        for (int i = 9; i >= 0; i--) if (model[i] == mx) e.cls = i;
        other = 0;
        for (int i = 0; i < 10; i++)
            if (i != e.cls && model[i] > other) other = model[i];
        e.cnt = mx;
        e.margin = mx - other;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (bus.result_valid !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        bus.result_ready = 0;
        bus_s.result_ready = 0;
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        vectors++;
        if ({bus.result_valid, bus.busy, bus.sat_err} !== 3'b000) begin
            $display("FAIL reset_flags got %b want 000",
                     {bus.result_valid, bus.busy, bus.sat_err});
            errors++;
        end
        vectors++;
        if ({bus.result_class, bus.result_count} !== 12'h000) begin
            $display("FAIL reset_result got %h want 000",
                     {bus.result_class, bus.result_count});
            errors++;
        end
        vectors++;
        if ({bus_s.result_valid, bus_s.busy, bus_s.sat_err} !== 3'b000) begin
            $display("FAIL reset_flags_s got %b want 000",
                     {bus_s.result_valid, bus_s.busy, bus_s.sat_err});
            errors++;
        end
    endtask

    task automatic test_basic_vote();
        exp_t e;
        int n;
        do_start();
        vectors++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL basic_busy got %b want 1", bus.busy);
            errors++;
        end
        for (int it = 0; it < 4; it++) begin
            if (it < 2) cyc(1, 7, 1, 0);
            cyc(1, 1, 0, 0);
            cyc(1, 3, 1, 1);
        end
        push_expected();
        wait_valid(40, n);
        e = sb.pop_front();
        vectors++;
        if (n !== 11) begin
            $display("FAIL basic_latency got %0d want 11", n);
            errors++;
        end
        vectors++;
        if (bus.result_class !== 4'(e.cls) || bus.result_count !== 8'(e.cnt)) begin
            $display("FAIL basic_result got %0d/%0d want %0d/%0d",
                     bus.result_class, bus.result_count, e.cls, e.cnt);
            errors++;
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.sat_err !== 1'b0) begin
            $display("FAIL basic_status got busy %b sat %b want 0 0",
                     bus.busy, bus.sat_err);
            errors++;
        end
`ifdef RBM_VOTE_MARGIN_EN
        vectors++;
        if (bus.result_margin !== 8'(e.margin)) begin
            $display("FAIL basic_margin got %0d want %0d",
                     bus.result_margin, e.margin);
            errors++;
        end
`endif
        bus.result_ready = 1;
        @(negedge clock);
        bus.result_ready = 0;
        vectors++;
        if (bus.result_valid !== 1'b0) begin
            $display("FAIL basic_accept got %b want 0", bus.result_valid);
            errors++;
        end
    endtask

    task automatic test_tie();
        exp_t e;
        int n;
        do_start();
        for (int it = 0; it < 4; it++) begin
            if (it < 3) begin
                cyc(1, 5, 1, 0);
                cyc(1, 2, 1, 0);
            end
            cyc(1, 4, 0, 1);
        end
        push_expected();
        bus.result_ready = 1;
        wait_valid(40, n);
        e = sb.pop_front();
        vectors++;
        if (bus.result_valid !== 1'b1 || bus.result_class !== 4'(e.cls) ||
            bus.result_count !== 8'(e.cnt)) begin
            $display("FAIL tie_result got v%b %0d/%0d want v1 %0d/%0d",
                     bus.result_valid, bus.result_class, bus.result_count,
                     e.cls, e.cnt);
            errors++;
        end
`ifdef RBM_VOTE_MARGIN_EN
        vectors++;
        if (bus.result_margin !== 8'(e.margin)) begin
            $display("FAIL tie_margin got %0d want %0d",
                     bus.result_margin, e.margin);
            errors++;
        end
`endif
        @(negedge clock);
        bus.result_ready = 0;
        vectors++;
        if (bus.result_valid !== 1'b0) begin
            $display("FAIL tie_accept got %b want 0", bus.result_valid);
            errors++;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int n;
        bus_s.start = 1;
        @(negedge clock);
        bus_s.start = 0;
        for (int k = 0; k < 9; k++) begin
            bus_s.spike_valid = 1;
            bus_s.spike_class = 4'd0;
            bus_s.spike = 1;
            bus_s.iter_done = (k == 8);
            @(negedge clock);
        end
        bus_s.spike_valid = 0; bus_s.spike = 0; bus_s.iter_done = 0;
        e.cls = 0; e.cnt = 7; e.margin = 7;
        sb.push_back(e);
        n = 0;
        while (bus_s.result_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        vectors++;
        if (bus_s.result_valid !== 1'b1 || bus_s.result_class !== 4'(e.cls) ||
            bus_s.result_count !== 3'(e.cnt)) begin
            $display("FAIL sat_result got v%b %0d/%0d want v1 %0d/%0d",
                     bus_s.result_valid, bus_s.result_class,
                     bus_s.result_count, e.cls, e.cnt);
            errors++;
        end
        vectors++;
        if (bus_s.sat_err !== 1'b1) begin
            $display("FAIL sat_err got %b want 1", bus_s.sat_err);
            errors++;
        end
`ifdef RBM_VOTE_MARGIN_EN
        vectors++;
        if (bus_s.result_margin !== 3'(e.margin)) begin
            $display("FAIL sat_margin got %0d want %0d",
                     bus_s.result_margin, e.margin);
            errors++;
        end
`endif
        bus_s.result_ready = 1;
        @(negedge clock);
        bus_s.result_ready = 0;
    endtask

    task automatic test_bad_class();
        exp_t e;
        int n;
        do_start();
        vectors++;
        if (bus.sat_err !== 1'b0) begin
            $display("FAIL badcls_clear got %b want 0", bus.sat_err);
            errors++;
        end
        repeat (3) cyc(1, 12, 1, 0);
        vectors++;
        if (bus.sat_err !== 1'b1) begin
            $display("FAIL badcls_sat got %b want 1", bus.sat_err);
            errors++;
        end
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        repeat (4) cyc(0, 0, 0, 1);
        push_expected();
        bus.result_ready = 1;
        wait_valid(40, n);
        e = sb.pop_front();
        vectors++;
        if (bus.result_valid !== 1'b1 || bus.result_class !== 4'(e.cls) ||
            bus.result_count !== 8'(e.cnt)) begin
            $display("FAIL badcls_result got v%b %0d/%0d want v1 %0d/%0d",
                     bus.result_valid, bus.result_class, bus.result_count,
                     e.cls, e.cnt);
            errors++;
        end
        @(negedge clock);
        bus.result_ready = 0;
    endtask

    task automatic test_hold();
        exp_t e;
        int n;
        do_start();
        for (int it = 0; it < 4; it++) begin
            cyc(1, 6, 1, 0);
            if (it == 0) cyc(1, 6, 1, 0);
            cyc(1, 8, it[0], 1);
        end
        push_expected();
        bus.result_ready = 0;
        wait_valid(40, n);
        e = sb.pop_front();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            vectors++;
            if (bus.result_valid !== 1'b1 || bus.result_class !== 4'(e.cls) ||
                bus.result_count !== 8'(e.cnt)) begin
                $display("FAIL hold_%0d got v%b %0d/%0d want v1 %0d/%0d", k,
                         bus.result_valid, bus.result_class,
                         bus.result_count, e.cls, e.cnt);
                errors++;
            end
        end
        bus.result_ready = 1;
        @(negedge clock);
        bus.result_ready = 0;
        vectors++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL hold_release got v%b busy %b want 0 0",
                     bus.result_valid, bus.busy);
            errors++;
        end
    endtask

    task automatic test_abort_and_reset();
        exp_t e;
        int n;
        do_start();
        repeat (4) cyc(1, 0, 1, 1);
        repeat (3) @(negedge clock);
        do_start();
        vectors++;
        if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
            $display("FAIL abort_state got busy %b v%b want 1 0",
                     bus.busy, bus.result_valid);
            errors++;
        end
        cyc(1, 8, 1, 0);
        repeat (4) cyc(0, 0, 0, 1);
        push_expected();
        bus.result_ready = 1;
        wait_valid(40, n);
        e = sb.pop_front();
        vectors++;
        if (n !== 11) begin
            $display("FAIL abort_latency got %0d want 11", n);
            errors++;
        end
        vectors++;
        if (bus.result_class !== 4'(e.cls) || bus.result_count !== 8'(e.cnt)) begin
            $display("FAIL abort_result got %0d/%0d want %0d/%0d",
                     bus.result_class, bus.result_count, e.cls, e.cnt);
            errors++;
        end
        @(negedge clock);
        bus.result_ready = 0;
        do_start();
        cyc(1, 12, 1, 0);
        cyc(1, 3, 1, 0);
        reset = 1;
        @(negedge clock);
        reset = 0;
        vectors++;
        if ({bus.result_valid, bus.busy, bus.sat_err} !== 3'b000 ||
            {bus.result_class, bus.result_count} !== 12'h000) begin
            $display("FAIL midreset got %b %h want 000 000",
                     {bus.result_valid, bus.busy, bus.sat_err},
                     {bus.result_class, bus.result_count});
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        bus.result_ready = 1;
        for (int d = 0; d < 2; d++) begin
            do_start();
            for (int it = 0; it < 4; it++) begin
                cyc(1, 4, (d == 0) || (it == 0), 0);
                cyc(1, 9, (d == 1) && (it < 2), 1);
            end
            push_expected();
            wait_valid(40, n);
            e = sb.pop_front();
            vectors++;
            if (bus.result_valid !== 1'b1 || bus.result_class !== 4'(e.cls) ||
                bus.result_count !== 8'(e.cnt)) begin
                $display("FAIL b2b_%0d got v%b %0d/%0d want v1 %0d/%0d", d,
                         bus.result_valid, bus.result_class,
                         bus.result_count, e.cls, e.cnt);
                errors++;
            end
            @(negedge clock);
        end
        bus.result_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic_vote();
        test_tie();
        test_saturation();
        test_bad_class();
        test_hold();
        test_abort_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
